// File: rtl/instruction_memory_loader_if.sv
// rtl/instruction_memory_loader_if.sv - byte stream, memory write port and readback bundle
// Ports (signals):
//   s_valid/s_data/s_ready          framed byte stream into the loader
//   mem_we/mem_waddr/mem_wdata      byte write port of the instruction memory
//   debug_enable/debug_addr/debug_rdata  readback path of the instruction memory
// Modports: master = host/memory side, slave = loader side.
interface instruction_memory_loader_if #(
    parameter int I_ADDR_W = 12
) ();
    logic                s_valid;
    logic [7:0]          s_data;
    logic                s_ready;
    logic                mem_we;
    logic [I_ADDR_W-1:0] mem_waddr;
    logic [7:0]          mem_wdata;
    logic                debug_enable;
    logic [I_ADDR_W-1:0] debug_addr;
    logic [15:0]         debug_rdata;

    modport master (
        output s_valid, s_data, debug_rdata,
        input  s_ready, mem_we, mem_waddr, mem_wdata, debug_enable, debug_addr
    );

    modport slave (
        input  s_valid, s_data, debug_rdata,
        output s_ready, mem_we, mem_waddr, mem_wdata, debug_enable, debug_addr
    );
endinterface

// File: rtl/instruction_memory_loader.sv
// rtl/instruction_memory_loader.sv - framed byte-stream loader for the instruction memory
// Frame: LEN_LO, LEN_HI, N payload bytes, CSUM (sum of payload mod 256).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, base_addr  begin a frame, first write address (latched on start)
//   abort             return to IDLE from any state, kills the pending write
//   bus (slave)       stream in, memory write port out, readback path
//   cpu_hold          stalls CPU fetch while a frame is in flight or failed
//   load_done         sticky success flag
//   load_error        sticky code: 0 none, 1 length overflow, 2 checksum, 3 readback
// Optional feature: IMEM_LOADER_READBACK_EN adds a VERIFY pass that re-reads the
// written range through the debug port and re-checks the checksum.
module instruction_memory_loader #(
    parameter int I_ADDR_W       = 12,
    parameter int I_MEMORY_DEPTH = 1 << I_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [I_ADDR_W-1:0]         base_addr,
    input  logic                        abort,
    instruction_memory_loader_if.slave  bus,
    output logic                        cpu_hold,
    output logic                        load_done,
    output logic [1:0]                  load_error
);
    // Wide enough that base_addr + 16-bit length can never wrap.
    localparam int CHK_W = I_ADDR_W + 17;
    localparam logic [CHK_W-1:0] DEPTH_EXT = CHK_W'(I_MEMORY_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
`ifdef IMEM_LOADER_READBACK_EN
        , ST_VERIFY
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [I_ADDR_W-1:0] base_q, base_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          sum_q, sum_d;
    logic                we_q, we_d;
    logic [I_ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;

    logic                s_ready_int;
    logic                accept;
    logic [15:0]         len_full;
    logic                overflow;

`ifdef IMEM_LOADER_READBACK_EN
    logic [7:0]          csum_q, csum_d;
    logic [I_ADDR_W-1:0] vaddr_q, vaddr_d;
    logic [7:0]          vsum_q, vsum_d;
    logic [7:0]          vsum_next;
    logic                unused_rdata;

    assign vsum_next    = vsum_q + bus.debug_rdata[7:0];
    assign unused_rdata = ^bus.debug_rdata[15:8];
`else
    logic                unused_rdata;

    assign unused_rdata = ^bus.debug_rdata;
`endif

    // abort also drops s_ready so a byte offered alongside abort is never taken.
    assign s_ready_int = ((state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                          (state_q == ST_DATA)   || (state_q == ST_CSUM)) && !abort;
    assign accept      = bus.s_valid && s_ready_int;
    assign len_full    = {bus.s_data, len_q[7:0]};
    assign overflow    = (CHK_W'(base_q) + CHK_W'(len_full)) > DEPTH_EXT;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_READBACK_EN
        csum_d  = csum_q;
        vaddr_d = vaddr_q;
        vsum_d  = vsum_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_LO;
                    base_d  = base_addr;
                    cnt_d   = 16'd0;
                    sum_d   = 8'd0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 2'd0;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, bus.s_data};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (overflow) begin
                        state_d = ST_ERROR;
                        err_d   = 2'd1;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = base_q + I_ADDR_W'(cnt_q);
                    wdata_d = bus.s_data;
                    sum_d   = sum_q + bus.s_data;
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (bus.s_data != sum_q) begin
                        state_d = ST_ERROR;
                        err_d   = 2'd2;
`ifdef IMEM_LOADER_READBACK_EN
                    end else if (len_q != 16'd0) begin
                        state_d = ST_VERIFY;
                        csum_d  = bus.s_data;
                        vaddr_d = base_q;
                        vsum_d  = 8'd0;
                        cnt_d   = 16'd0;
`endif
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end
                end
            end
`ifdef IMEM_LOADER_READBACK_EN
            ST_VERIFY: begin
                // Memory reads are combinational: rdata belongs to vaddr_q this cycle.
                vsum_d  = vsum_next;
                vaddr_d = vaddr_q + 1'b1;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q + 16'd1 == len_q) begin
                    if (vsum_next == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 2'd3;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // abort outranks everything, including a simultaneous start.
        if (abort) begin
            state_d = ST_IDLE;
            hold_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 2'd0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= 16'd0;
            cnt_q   <= 16'd0;
            sum_q   <= 8'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'd0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 2'd0;
`ifdef IMEM_LOADER_READBACK_EN
            csum_q  <= 8'd0;
            vaddr_q <= '0;
            vsum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_READBACK_EN
            csum_q  <= csum_d;
            vaddr_q <= vaddr_d;
            vsum_q  <= vsum_d;
`endif
        end
    end

    assign bus.s_ready   = s_ready_int;
    // The registered write is suppressed in the cycle abort arrives.
    assign bus.mem_we    = we_q && !abort;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;

`ifdef IMEM_LOADER_READBACK_EN
    assign bus.debug_enable = (state_q == ST_VERIFY);
    assign bus.debug_addr   = vaddr_q;
`else
    assign bus.debug_enable = 1'b0;
    assign bus.debug_addr   = '0;
`endif

    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;
endmodule

// File: tb/tb_instruction_memory_loader.sv
// tb/tb_instruction_memory_loader.sv - self-checking bench for instruction_memory_loader
module tb_instruction_memory_loader;
`ifdef IMEM_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] base;
        logic [15:0] n;
        logic [31:0] d;
        logic [7:0]  csum;
        logic        gap;
        logic        corrupt;
        logic        exp_done;
        logic [1:0]  exp_err;
        logic        exp_hold;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] base_in = '0;
    logic        cpu_hold;
    logic        load_done;
    logic [1:0]  load_error;

    logic [7:0]  tb_mem [4096];
    logic        corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = '0;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  rise_cyc = -1;
    bit  flag_prev = 1'b0;
    wr_t exp_q[$];
    vec_t vecs[11];

    instruction_memory_loader_if #(.I_ADDR_W(12)) bus ();

    instruction_memory_loader #(.I_ADDR_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_in),
        .abort      (abort),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Instruction memory model: registered byte writes, combinational readback.
    always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_waddr] <= bus.mem_wdata;
    always_comb begin
        bus.debug_rdata = {8'hEE, tb_mem[bus.debug_addr] ^
                          ((corrupt_en && bus.debug_addr == corrupt_addr) ? 8'h5A : 8'h00)};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write scoreboard and flag-rise tracker.
    always @(negedge clk) begin
        wr_t e;
        logic flag_now;
        if (!rst_n || abort) exp_q.delete();
        if (bus.mem_we) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write addr=%h data=%h required=none", bus.mem_waddr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_waddr !== e.addr || bus.mem_wdata !== e.data || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL write actual=%h:%h@%0d required=%h:%h@%0d",
                             bus.mem_waddr, bus.mem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_write actual=none required=%h:%h@%0d", exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        flag_now = load_done || (load_error != 2'd0);
        if (flag_now && !flag_prev) rise_cyc = cyc;
        flag_prev = flag_now;
    end

    // Offer one byte (optionally after an idle cycle); ok=0 if never accepted.
    task automatic send_byte(input logic [7:0] b, input logic gap, output bit ok, output int ac);
        ok = 1'b0;
        ac = -1;
        if (gap) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                ac = cyc;
            end
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] b);
        start   = 1'b1;
        base_in = b;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic push_write(input logic [11:0] a, input logic [7:0] d, input int ac);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = ac + 1;
        exp_q.push_back(e);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit ok;
        int ac;
        int last;
        int nb;
        int lat;
        logic [7:0] b;
        rise_cyc     = -1;
        corrupt_en   = v.corrupt;
        corrupt_addr = v.base + 12'd1;
        do_start(v.base);
        send_byte(v.n[7:0], v.gap, ok, ac);
        last = ac;
        if (ok) begin
            send_byte(v.n[15:8], v.gap, ok, ac);
            if (ok) last = ac;
        end
        nb = (v.n > 16'd4) ? 4 : int'(v.n);
        for (int i = 0; i < nb && ok; i++) begin
            b = v.d[8*i +: 8];
            send_byte(b, v.gap, ok, ac);
            if (ok) begin
                push_write(v.base + 12'(i), b, ac);
                last = ac;
            end
        end
        if (ok) begin
            send_byte(v.csum, v.gap, ok, ac);
            if (ok) last = ac;
        end
        for (int t = 0; t < 64 && rise_cyc < 0; t++) @(negedge clk);
        lat = 1 + ((RB && (v.exp_err == 2'd0 || v.exp_err == 2'd3) && v.n != 16'd0) ? int'(v.n) : 0);
        check($sformatf("v%0d_latency", idx), 64'(rise_cyc - last), 64'(lat));
        @(negedge clk);
        check($sformatf("v%0d_status", idx), {load_done, load_error, cpu_hold},
              {v.exp_done, v.exp_err, v.exp_hold});
        check($sformatf("v%0d_s_ready", idx), bus.s_ready, 1'b0);
        check($sformatf("v%0d_writes_drained", idx), exp_q.size(), 0);
        corrupt_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        int ac;
        for (int i = 0; i < 4096; i++) tb_mem[i] = 8'h00;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        //           base     n        payload (LSB first)  csum   gap  cor  done err  hold
        vecs[0]  = '{12'h010, 16'd3,    32'h00332211, 8'h66, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{12'hFFE, 16'd3,    32'h00030201, 8'h06, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[2]  = '{12'h100, 16'd2,    32'h0000BBAA, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};
        vecs[3]  = '{12'h000, 16'd0,    32'h00000000, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{12'h000, 16'd0,    32'h00000000, 8'h01, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};
        vecs[5]  = '{12'h200, 16'd4,    32'h04030201, 8'h0A, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[6]  = '{12'hFFD, 16'd3,    32'h00C2B1A0, 8'h13, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[7]  = '{12'hFFD, 16'd4,    32'h04030201, 8'h0A, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[8]  = '{12'h300, 16'd3,    32'h00030201, 8'h06, 1'b0, 1'b1, !RB, RB ? 2'd3 : 2'd0, RB};
        vecs[9]  = '{12'hFFC, 16'd4,    32'h44332211, 8'hAA, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{12'h000, 16'h1001, 32'h00000000, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_a", {bus.s_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata, cpu_hold, load_done, load_error}, 64'd0);
        check("reset_outputs_b", {bus.debug_enable, bus.debug_addr}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        check("top_byte_written", tb_mem[12'hFFF], 8'h44);

        // start and abort together: abort wins, loader stays idle.
        abort = 1'b1;
        do_start(12'h080);
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_ready", bus.s_ready, 1'b0);
        check("start_abort_hold", cpu_hold, 1'b0);
        @(posedge clk); #1;

        // abort mid-DATA: the pending write is killed, nothing follows.
        do_start(12'h400);
        send_byte(8'h08, 1'b0, ok, ac);
        send_byte(8'h00, 1'b0, ok, ac);
        send_byte(8'h5A, 1'b0, ok, ac);
        if (ok) push_write(12'h400, 8'h5A, ac);
        send_byte(8'h6B, 1'b0, ok, ac);
        if (ok) push_write(12'h401, 8'h6B, ac);
        abort       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h7C;
        @(negedge clk);
        check("abort_we_same_cycle", bus.mem_we, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        check("abort_status", {load_done, load_error, cpu_hold, bus.s_ready}, 64'd0);
        check("abort_kept_byte", tb_mem[12'h400], 8'h5A);
        check("abort_killed_byte", tb_mem[12'h401], 8'h00);

        // reset mid-DATA: outputs drop at once, earlier bytes stay in memory.
        do_start(12'h500);
        send_byte(8'h04, 1'b0, ok, ac);
        send_byte(8'h00, 1'b0, ok, ac);
        send_byte(8'h11, 1'b0, ok, ac);
        if (ok) push_write(12'h500, 8'h11, ac);
        send_byte(8'h22, 1'b0, ok, ac);
        if (ok) push_write(12'h501, 8'h22, ac);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs_a", {bus.s_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata, cpu_hold, load_done, load_error}, 64'd0);
        check("midreset_outputs_b", {bus.debug_enable, bus.debug_addr}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_kept_byte", tb_mem[12'h500], 8'h11);
        check("midreset_lost_byte", tb_mem[12'h501], 8'h00);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
